// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM byte-access controller: default geometry
// and the request/response sequencer state encoding.
package bram_ctrl_pkg;

    localparam int SIZE_DEF       = 512;
    localparam int ADDR_WIDTH_DEF = 9;
    localparam int DI_WIDTH_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2,
        RSP     = 2'd3
    } state_e;

endpackage

// File: rtl/bram_byte_access_ctrl.sv
// Request/response front end for a read-first, byte-enable single-port BRAM.
// Optional macro BRAM_CTRL_WR_ACK_EN: writes also return the pre-write word.
module bram_byte_access_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int SIZE       = SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DI_WIDTH   = DI_WIDTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [1:0]              req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DI_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DI_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [1:0]              ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [2*DI_WIDTH-1:0]   ram_di,
    input  logic [2*DI_WIDTH-1:0]   ram_do
);

    localparam int unsigned SIZE_U = SIZE;

    state_e                  state_q, state_d;
    logic [1:0]              ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [2*DI_WIDTH-1:0]   ram_di_q, ram_di_d;
    logic [2*DI_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    err_q, err_d;

    logic accept;
    logic in_range;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = (32'(req_addr) < SIZE_U);

    always_comb begin
        state_d     = state_q;
        ram_we_d    = 2'b00;
        ram_addr_d  = ram_addr_q;
        ram_di_d    = ram_di_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_addr_d = req_addr;
                    if (req_wr) begin
                        ram_di_d = req_wdata;
                        // Out-of-range writes are swallowed: no strobe reaches the RAM.
                        if (in_range) ram_we_d = req_be;
`ifdef BRAM_CTRL_WR_ACK_EN
                        state_d = RD_WAIT;
                        err_d   = !in_range;
`endif
                    end else begin
                        state_d = RD_WAIT;
                        err_d   = !in_range;
                    end
                end
            end
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                // ram_do now carries the word read (pre-write for acked writes).
                rsp_rdata_d = err_q ? '0 : ram_do;
                rsp_err_d   = err_q;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            ram_we_q    <= 2'b00;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_q       <= err_d;
        end
    end

    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_di    = ram_di_q;

endmodule

// File: doc/bram_byte_access_ctrl.md
BRAM_BYTE_ACCESS_CTRL -- requirements
Module: bram_byte_access_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 512, number of RAM words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width.
REQ-003 SHALL have parameter DI_WIDTH, default 8, byte-lane width; data width is 2*DI_WIDTH.
REQ-004 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-007 SHALL have ports req_wr in 1 (1=write), req_be in 2 (byte enables, [1]=high lane), req_addr in ADDR_WIDTH, req_wdata in 2*DI_WIDTH.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 2*DI_WIDTH, rsp_err out 1: response handshake.
REQ-009 SHALL have ports ram_we out 2, ram_addr out ADDR_WIDTH, ram_di out 2*DI_WIDTH, ram_do in 2*DI_WIDTH: drive a read-first, byte-write-enable single-port block RAM with 1-cycle registered read.

Function
REQ-010 SHALL accept a request on a rising edge with req_valid && req_ready.
REQ-011 SHALL implement FSM states IDLE, RD_WAIT, RD_CAP, RSP; req_ready = 1 only in IDLE.
REQ-012 On accepted write with req_addr < SIZE: ram_we <= req_be, ram_addr <= req_addr, ram_di <= req_wdata at the accept edge; ram_we returns to 0 at the next edge unless another write is accepted.
REQ-013 Writes SHALL sustain one per cycle; FSM stays IDLE (macro absent).
REQ-014 req_be = 2'b00 write SHALL be accepted and issue ram_we = 0 (no RAM change).
REQ-015 On accepted read: ram_addr <= req_addr, ram_we <= 0; IDLE->RD_WAIT; RD_WAIT->RD_CAP unconditionally; in RD_CAP, rsp_rdata <= ram_do, ->RSP.
REQ-016 Accept-to-rsp_valid latency SHALL be exactly 3 edges (accept edge E0, rsp_valid high after E2).
REQ-017 In RSP, rsp_valid = 1 and rsp_rdata/rsp_err stable until rsp_valid && rsp_ready; then ->IDLE, req_ready high the following cycle.
REQ-018 req_addr >= SIZE: write accepted and dropped (ram_we = 0); read proceeds through FSM with rsp_rdata = 0, rsp_err = 1; otherwise rsp_err = 0.
REQ-019 ram_addr and ram_di SHALL hold their last values when no request is accepted.
REQ-020 req_* inputs SHALL be ignored when req_ready = 0.

Reset
REQ-021 RST_N low SHALL immediately force state IDLE, ram_we = 0, ram_addr = 0, ram_di = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-022 Reset asserted mid-read or mid-response SHALL discard that transaction; no response after deassertion.
REQ-023 req_ready SHALL be 1 in the first cycle after RST_N deasserts.

Configuration
REQ-024 Macro BRAM_CTRL_WR_ACK_EN defined: every accepted write follows the read path (RD_WAIT, RD_CAP, RSP) and returns the pre-write word (RAM read-first value) on rsp_rdata; write throughput one per 4 cycles minimum.
REQ-025 Macro absent: writes produce no response; rsp_valid only for reads.

Structure
REQ-026 Package bram_ctrl_pkg SHALL hold the FSM state enumeration and default SIZE/ADDR_WIDTH/DI_WIDTH constants.
REQ-027 No sub-module; the RAM is instantiated by the parent, not inside this block.

Verification (bench instantiates block plus the 512x16 read-first byte-enable RAM)
REQ-028 Reset then write addr 0x005 data 0xA55A be 2'b11, read 0x005 -> rsp_rdata 0xA55A, rsp_err 0, rsp_valid 3 edges after accept.
REQ-029 Write 0x010 = 0x1234 be 11, then 0xFFEE be 01, then 0x9900 be 10, read 0x010 -> 0x99EE.
REQ-030 Read with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-031 SIZE=300: read 0x12C -> rsp_rdata 0, rsp_err 1; write 0x12C -> ram_we stays 0.
REQ-032 With BRAM_CTRL_WR_ACK_EN: 0x020 holds 0x1111, write 0x2222 be 11 -> rsp_rdata 0x1111; subsequent read -> 0x2222.
REQ-033 RST_N pulsed low during RD_CAP -> rsp_valid never asserts, req_ready 1 after release.
